// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   state_t          fetch FSM states (ERR exists only with IFU_ALIGN_CHECK_EN)
//   WORD_BYTES       instruction size in bytes, the sequential PC step
//   DEFAULT_NOP_INST value presented on inst while nothing is held
package ifu_pkg;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;
`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
`endif
endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with a one-entry decode holding slot.
//   clock, reset             rising-edge clock, asynchronous active-high reset
//   pc / npc                 current PC in, next PC out to the external PC register
//   imem_req/addr/gnt        request channel to instruction memory
//   imem_rvalid/rdata        response channel from instruction memory
//   redir / redir_target     branch/jump redirect, highest priority
//   inst_valid/inst/inst_pc  instruction offered to decode, inst_ready accepts it
//   fetch_err                misaligned fetch flag, only with IFU_ALIGN_CHECK_EN
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redir,
    input  logic [31:0] redir_target,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IFU_ALIGN_CHECK_EN
    ,
    output logic        fetch_err
`endif
);
    state_t      state;
    logic        discard;
    logic [31:0] inst_q;
    logic        misaligned;

`ifdef IFU_ALIGN_CHECK_EN
    assign misaligned = pc[1:0] != 2'b00;
    assign imem_addr  = pc;
    assign fetch_err  = state == ERR;
`else
    assign misaligned = 1'b0;
    assign imem_addr  = {pc[31:2], 2'b00};
`endif

    assign imem_req   = state == REQ && !misaligned;
    assign inst_valid = state == HOLD;
    assign inst       = inst_valid ? inst_q : NOP_INST;
    // redirect beats the handshake, so a redirected HOLD never advances by a word
    assign npc = reset ? pc :
                 redir ? redir_target :
                 (inst_valid && inst_ready) ? pc + 32'(WORD_BYTES) : pc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            discard <= 1'b0;
            inst_q  <= NOP_INST;
            inst_pc <= '0;
        end else begin
            case (state)
                IDLE: state <= redir ? IDLE : REQ;
                REQ: begin
`ifdef IFU_ALIGN_CHECK_EN
                    if (misaligned)
                        state <= redir ? REQ : ERR;
                    else
`endif
                    if (imem_gnt) begin
                        state   <= WAIT;
                        discard <= redir;
                    end
                end
                WAIT: begin
                    // a redirect in flight makes the returning word stale
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        if (discard || redir)
                            state <= REQ;
                        else begin
                            state   <= HOLD;
                            inst_q  <= imem_rdata;
                            inst_pc <= pc;
                        end
                    end else if (redir)
                        discard <= 1'b1;
                end
                HOLD: state <= (redir || inst_ready) ? REQ : HOLD;
`ifdef IFU_ALIGN_CHECK_EN
                ERR: state <= redir ? REQ : ERR;
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed and randomized check of ifu_fetch against a transaction-level model.
module tb_ifu_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] npc, imem_addr, inst, inst_pc;
    logic        imem_req, inst_valid;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, redir = 1'b0, inst_ready = 1'b0;
    logic [31:0] imem_rdata = '0, redir_target = '0;
`ifdef IFU_ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    ifu_fetch #(.NOP_INST(NOP)) dut (
        .clock(clock), .reset(reset), .pc(pc), .npc(npc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redir(redir), .redir_target(redir_target),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
`ifdef IFU_ALIGN_CHECK_EN
        , .fetch_err(fetch_err)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // model: where the fetch transaction stands, not how the FSM encodes it
    bit          m_idle, m_pending, m_stale, m_hold, m_err;
    logic [31:0] m_inst, m_ipc, m_npc, pc_next;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic bit bad_align(input logic [31:0] a);
`ifdef IFU_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return a[1:0] != 2'b00 && 1'b0;
`endif
    endfunction

    task automatic do_reset(input logic [31:0] rpc);
        @(negedge clock);
        #2;
        reset = 1'b1;
        pc = rpc;
        redir = 1'b1; redir_target = 32'hDEAD_BEE0;
        inst_ready = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b1;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, NOP);
        check("rst_ipc", inst_pc, 32'd0);
        check("rst_npc", npc, rpc);
`ifdef IFU_ALIGN_CHECK_EN
        check("rst_ferr", 32'(fetch_err), 32'd0);
`endif
        m_idle = 1; m_pending = 0; m_stale = 0; m_hold = 0; m_err = 0;
        m_inst = NOP; m_ipc = '0; pc_next = rpc;
    endtask

    task automatic drive(input logic r, input logic [31:0] t, input logic rdy,
                         input logic g, input logic rv, input logic [31:0] rd);
        logic er;
        @(negedge clock);
        reset = 1'b0;
        pc = pc_next;
        redir = r; redir_target = t; inst_ready = rdy;
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        #1;
        er = !m_idle && !m_pending && !m_hold && !m_err && !bad_align(pc);
        m_npc = r ? t : (m_hold && rdy) ? pc + 32'd4 : pc;
        check("req", 32'(imem_req), 32'(er));
`ifdef IFU_ALIGN_CHECK_EN
        if (er) check("addr", imem_addr, pc);
        check("ferr", 32'(fetch_err), 32'(m_err));
`else
        if (er) check("addr", imem_addr, pc & ~32'h3);
`endif
        check("valid", 32'(inst_valid), 32'(m_hold));
        check("inst", inst, m_hold ? m_inst : NOP);
        if (m_hold) check("ipc", inst_pc, m_ipc);
        check("npc", npc, m_npc);
    endtask

    task automatic tick();
        if (m_idle)
            m_idle = redir;
        else if (m_err)
            m_err = !redir;
        else if (m_hold)
            m_hold = !(redir || inst_ready);
        else if (m_pending) begin
            if (imem_rvalid) begin
                m_pending = 0;
                if (!(m_stale || redir)) begin
                    m_hold = 1; m_inst = imem_rdata; m_ipc = pc;
                end
                m_stale = 0;
            end else if (redir)
                m_stale = 1;
        end else if (bad_align(pc)) begin
            if (!redir) m_err = 1;
        end else if (imem_gnt) begin
            m_pending = 1; m_stale = redir;
        end
        pc_next = m_npc;
        @(posedge clock);
    endtask

    task automatic step(input logic r, input logic [31:0] t, input logic rdy,
                        input logic g, input logic rv, input logic [31:0] rd);
        drive(r, t, rdy, g, rv, rd);
        tick();
    endtask

    initial begin
        logic        r, rv;
        logic [31:0] t;
        do_reset(32'h0000_3000);
        drive(0, 0, 0, 0, 0, 0);
        check("idle_req", 32'(imem_req), 32'd0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        check("first_addr", imem_addr, 32'h0000_3000);
        check("first_req", 32'(imem_req), 32'd1);
        tick();
        step(0, 0, 0, 0, 1, 32'h2008_0005);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 32'h5555_AAAA);
            check("stall_inst", inst, 32'h2008_0005);
            check("stall_ipc", inst_pc, 32'h0000_3000);
            check("stall_npc", npc, 32'h0000_3000);
            tick();
        end
        drive(0, 0, 1, 0, 0, 0);
        check("accept_npc", npc, 32'h0000_3004);
        tick();
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h0000_3040, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hBAD0_BAD0);
        drive(0, 0, 0, 1, 0, 0);
        check("redir_addr", imem_addr, 32'h0000_3040);
        check("drop_valid", 32'(inst_valid), 32'd0);
        tick();
        step(0, 0, 0, 0, 1, 32'h1111_2222);
        drive(1, 32'h0000_5000, 1, 0, 0, 0);
        check("hold_redir_npc", npc, 32'h0000_5000);
        tick();
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        check("req_redir_valid", 32'(inst_valid), 32'd0);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        step(0, 0, 0, 0, 1, 32'h0000_0073);
        drive(0, 0, 1, 0, 0, 0);
        check("wrap_npc", npc, 32'h0000_0000);
        tick();
`ifdef IFU_ALIGN_CHECK_EN
        step(1, 32'h0000_3002, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        check("mis_req", 32'(imem_req), 32'd0);
        tick();
        drive(0, 0, 0, 1, 1, 0);
        check("err_flag", 32'(fetch_err), 32'd1);
        check("err_npc", npc, 32'h0000_3002);
        tick();
        drive(1, 32'h0000_3000, 0, 0, 0, 0);
        check("err_redir_npc", npc, 32'h0000_3000);
        tick();
        drive(0, 0, 0, 1, 0, 0);
        check("err_clear", 32'(fetch_err), 32'd0);
        check("err_resume", imem_addr, 32'h0000_3000);
        tick();
`endif
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset($urandom & ~32'h3);
            r = ($urandom_range(7) == 0);
            t = $urandom & ~32'h3;
`ifdef IFU_ALIGN_CHECK_EN
            if ($urandom_range(3) == 0) t[1:0] = 2'($urandom_range(3, 1));
`endif
            rv = m_pending ? ($urandom_range(9) < 6) : ($urandom_range(9) < 2);
            step(r, t, 1'($urandom_range(1)), 1'($urandom_range(1)), rv, $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The parameter list SHALL be: NOP_INST, 32'h0000_0000, value driven on inst when no instruction is held.
REQ-002 The port list SHALL be: clock in 1, rising-edge clock.
REQ-003 The port list SHALL be: reset in 1, asynchronous, active-high.
REQ-004 The port list SHALL be: pc in 32, current PC from the PC register.
REQ-005 The port list SHALL be: npc out 32, next PC fed back to the PC register.
REQ-006 The port list SHALL be: imem_req out 1, fetch request valid.
REQ-007 The port list SHALL be: imem_addr out 32, fetch byte address.
REQ-008 The port list SHALL be: imem_gnt in 1, request accepted this cycle.
REQ-009 The port list SHALL be: imem_rvalid in 1, read data valid.
REQ-010 The port list SHALL be: imem_rdata in 32, read data.
REQ-011 The port list SHALL be: redir in 1, branch/jump redirect.
REQ-012 The port list SHALL be: redir_target in 32, redirect address.
REQ-013 The port list SHALL be: inst_valid out 1, instruction offered to decode.
REQ-014 The port list SHALL be: inst out 32, held instruction.
REQ-015 The port list SHALL be: inst_pc out 32, PC of the held instruction.
REQ-016 The port list SHALL be: inst_ready in 1, decode accepts.
REQ-017 The port list SHALL be: fetch_err out 1, misaligned fetch; present only with IFU_ALIGN_CHECK_EN.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, HOLD, plus ERR (macro only), and a discard flag.
REQ-019 IDLE SHALL last one cycle after reset release, then move to REQ.
REQ-020 REQ SHALL drive imem_req=1 and imem_addr=pc; on imem_gnt it SHALL move to WAIT.
REQ-021 Only one request SHALL be outstanding.
REQ-022 In WAIT with imem_rvalid and discard=0, the block SHALL capture inst=imem_rdata and inst_pc=pc, then move to HOLD.
REQ-023 In WAIT with imem_rvalid and discard=1, the block SHALL drop the data, clear discard and move to REQ.
REQ-024 HOLD SHALL drive inst_valid=1 with inst and inst_pc stable until the handshake completes.
REQ-025 On inst_valid && inst_ready in HOLD, npc SHALL be pc+4 in that cycle and the FSM SHALL move to REQ; fetch-to-fetch latency SHALL be 3 cycles with zero-wait memory.
REQ-026 npc SHALL equal pc in every other cycle, so the PC holds.
REQ-027 pc+4 SHALL wrap modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-028 redir SHALL take priority over everything: npc=redir_target in that cycle.
REQ-029 On redir in IDLE or REQ without gnt, the state SHALL be unchanged and the request SHALL retry next cycle at the new pc.
REQ-030 On redir in REQ with gnt, the block SHALL move to WAIT with discard=1.
REQ-031 On redir in WAIT, the block SHALL set discard=1; if rvalid arrives in the same cycle, the data SHALL be dropped and the block SHALL move to REQ.
REQ-032 On redir in HOLD, the block SHALL drop inst_valid next cycle and move to REQ, even if inst_ready=1; the handshake SHALL not count.
REQ-033 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored.
REQ-034 When inst_valid=0, inst SHALL equal NOP_INST.

Reset
REQ-035 On reset, the block SHALL go to IDLE with discard=0, imem_req=0, inst_valid=0, inst=NOP_INST, inst_pc=0 and fetch_err=0.
REQ-036 npc SHALL equal pc during reset.
REQ-037 Reset mid-transaction SHALL abandon the outstanding request; the memory shares the same reset.

Configuration
REQ-038 With IFU_ALIGN_CHECK_EN defined, REQ with pc[1:0]!=0 SHALL hold imem_req=0, enter ERR, and keep fetch_err=1 and npc=pc until redir; then fetch_err SHALL clear and the FSM SHALL go to REQ.
REQ-039 With IFU_ALIGN_CHECK_EN undefined, the block SHALL have no ERR state and no fetch_err port, and imem_addr SHALL be {pc[31:2],2'b00}.

Structure
REQ-040 Package ifu_pkg SHALL hold the state enum, WORD_BYTES=4, and the default NOP_INST constant.
REQ-041 No sub-module SHALL be used; the FSM and datapath are small enough for one module.

Verification
REQ-042 Reset release with pc=32'h0000_3000 and zero-wait memory SHALL give imem_req at cycle 2, addr 0x3000; rdata 0x2008_0005 SHALL give inst_valid with inst_pc=0x3000; inst_ready SHALL then give npc=0x3004.
REQ-043 inst_ready=0 for 5 cycles SHALL hold inst, inst_pc and inst_valid stable with npc=pc.
REQ-044 redir=1 with target 0x0000_3040 in WAIT SHALL drop the subsequent rvalid; the next imem_addr SHALL be 0x3040.
REQ-045 redir and inst_ready together in HOLD SHALL give npc=redir_target, with no pc+4 advance.
REQ-046 pc=32'hFFFF_FFFC fetched and accepted SHALL give npc=32'h0000_0000.
REQ-047 With IFU_ALIGN_CHECK_EN, pc=0x3002 SHALL give fetch_err=1 and no imem_req; redir to 0x3000 SHALL clear fetch_err and resume fetching.
